// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm match unit and its channels.
// Optional feature macro used by the unit: CMP_GE_MODE_EN.
package alarm_pkg;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_ARMED = 2'd1,
    CH_FIRED = 2'd2
  } ch_state_t;

  localparam ch_state_t CH_RST_STATE = CH_IDLE;
  localparam logic      FLAG_RST     = 1'b0;

  // Channel-index width; a single channel still gets a one-bit select.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: target register, arm/fire FSM, match pulse and sticky flag.
// With CMP_GE_MODE_EN a per-channel greater-or-equal compare mode is stored.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned AUTO_REARM = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] count,
  input  logic             we,
  input  logic             arm,
  input  logic [WIDTH-1:0] value,
`ifdef CMP_GE_MODE_EN
  input  logic             ge,
`endif
  input  logic             clr,
  output logic             pulse,
  output logic             sticky,
  output logic             armed,
  output logic             sticky_nxt_c
);

  logic [WIDTH-1:0] target_q;
  ch_state_t        state_q;
  ch_state_t        state_d;
  logic             cmp_c;
  logic             pulse_d;
  logic             armed_d;

  // Compare the live count against the stored target.
`ifdef CMP_GE_MODE_EN
  logic ge_q;
  assign cmp_c = ge_q ? (count >= target_q) : (count == target_q);
`else
  assign cmp_c = (count == target_q);
`endif

  // Next state; a target write overrides any hit in the same cycle.
  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
    if (we) begin
      state_d = arm ? CH_ARMED : CH_IDLE;
    end else begin
      case (state_q)
        CH_IDLE: begin
          if (arm) state_d = CH_ARMED;
        end
        CH_ARMED: begin
          if (cmp_c) begin
            state_d = CH_FIRED;
            pulse_d = 1'b1;
          end
        end
        CH_FIRED: begin
          if (arm) begin
            state_d = CH_ARMED;
          end else if ((AUTO_REARM != 0) && !cmp_c) begin
            state_d = CH_ARMED;
          end
        end
        default: state_d = CH_RST_STATE;
      endcase
    end
    sticky_nxt_c = pulse_d | (sticky & ~clr);
    armed_d      = (state_d == CH_ARMED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target_q <= '0;
      state_q  <= CH_RST_STATE;
      pulse    <= FLAG_RST;
      sticky   <= FLAG_RST;
      armed    <= FLAG_RST;
`ifdef CMP_GE_MODE_EN
      ge_q     <= FLAG_RST;
`endif
    end else begin
      if (we) begin
        target_q <= value;
`ifdef CMP_GE_MODE_EN
        ge_q     <= ge;
`endif
      end
      state_q <= state_d;
      pulse   <= pulse_d;
      sticky  <= sticky_nxt_c;
      armed   <= armed_d;
    end
  end

endmodule

// File: rtl/alarm_match_unit.sv
// Multi-channel programmable alarm comparator for the stopwatch datapath.
// Define CMP_GE_MODE_EN to add the cfg_ge port and >= compare mode.
module alarm_match_unit
  import alarm_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned AUTO_REARM = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [WIDTH-1:0]                  count,
  input  logic                              cfg_we,
  input  logic [ch_idx_w(CHANNELS)-1:0]     cfg_ch,
  input  logic [WIDTH-1:0]                  cfg_value,
  input  logic                              cfg_arm,
`ifdef CMP_GE_MODE_EN
  input  logic                              cfg_ge,
`endif
  input  logic [CHANNELS-1:0]               clr_sticky,
  output logic [CHANNELS-1:0]               match_pulse,
  output logic [CHANNELS-1:0]               match_sticky,
  output logic [CHANNELS-1:0]               armed,
  output logic                              any_match
);

  localparam int unsigned CH_IDX_W = ch_idx_w(CHANNELS);

  logic                ch_ok_c;
  logic [CHANNELS-1:0] we_c;
  logic [CHANNELS-1:0] arm_c;
  logic [CHANNELS-1:0] sticky_nxt_c;

  // Out-of-range channel indices are dropped here.
  assign ch_ok_c = (32'(cfg_ch) < CHANNELS);

  always_comb begin
    we_c  = '0;
    arm_c = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (ch_ok_c && (cfg_ch == CH_IDX_W'(i))) begin
        we_c[i]  = cfg_we;
        arm_c[i] = cfg_arm;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    alarm_channel #(
      .WIDTH      (WIDTH),
      .AUTO_REARM (AUTO_REARM)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .count        (count),
      .we           (we_c[g]),
      .arm          (arm_c[g]),
      .value        (cfg_value),
`ifdef CMP_GE_MODE_EN
      .ge           (cfg_ge),
`endif
      .clr          (clr_sticky[g]),
      .pulse        (match_pulse[g]),
      .sticky       (match_sticky[g]),
      .armed        (armed[g]),
      .sticky_nxt_c (sticky_nxt_c[g])
    );
  end

  // Registered from next-cycle sticky so it stays aligned with match_sticky.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      any_match <= FLAG_RST;
    end else begin
      any_match <= |sticky_nxt_c;
    end
  end

endmodule

// File: tb/tb_alarm_match_unit.sv
// Directed bench for alarm_match_unit: a default DUT and a 3-channel auto-rearm DUT.
module tb_alarm_match_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] count;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_value;
  logic        cfg_arm;
  logic        cfg_ge;
  logic [3:0]  clr_sticky;

  logic [3:0]  pulse, sticky, armed;
  logic        any;
  logic [2:0]  ar_pulse, ar_sticky, ar_armed;
  logic        ar_any;

  int n_chk  = 0;
  int n_fail = 0;
  int pulses;

  always #5 clk = ~clk;

  alarm_match_unit #(.WIDTH(16), .CHANNELS(4), .AUTO_REARM(0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .count        (count),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_value    (cfg_value),
    .cfg_arm      (cfg_arm),
`ifdef CMP_GE_MODE_EN
    .cfg_ge       (cfg_ge),
`endif
    .clr_sticky   (clr_sticky),
    .match_pulse  (pulse),
    .match_sticky (sticky),
    .armed        (armed),
    .any_match    (any)
  );

  alarm_match_unit #(.WIDTH(16), .CHANNELS(3), .AUTO_REARM(1)) dut_ar (
    .clk          (clk),
    .rst_n        (rst_n),
    .count        (count),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_value    (cfg_value),
    .cfg_arm      (cfg_arm),
`ifdef CMP_GE_MODE_EN
    .cfg_ge       (cfg_ge),
`endif
    .clr_sticky   (clr_sticky[2:0]),
    .match_pulse  (ar_pulse),
    .match_sticky (ar_sticky),
    .armed        (ar_armed),
    .any_match    (ar_any)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cfg();
    cfg_we = 1'b0; cfg_arm = 1'b0; cfg_ge = 1'b0; clr_sticky = '0;
  endtask

  initial begin
    rst_n = 1'b0; count = '0; cfg_ch = '0; cfg_value = '0;
    idle_cfg();

    // reset
    tick(); tick();
    check_eq("rst_pulse",  32'(pulse),  32'h0);
    check_eq("rst_sticky", 32'(sticky), 32'h0);
    check_eq("rst_armed",  32'(armed),  32'h0);
    check_eq("rst_any",    32'(any),    32'h0);
    check_eq("rst_ar_armed", 32'(ar_armed), 32'h0);
    rst_n = 1'b1;

    // basic fire on ch1
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_value = 16'h0030; tick();
    idle_cfg(); cfg_arm = 1'b1; cfg_ch = 2'd1; tick();
    idle_cfg();
    check_eq("basic_armed", 32'(armed), 32'h2);
    count = 16'h002E; tick();
    check_eq("basic_2e_pulse", 32'(pulse), 32'h0);
    count = 16'h002F; tick();
    check_eq("basic_2f_pulse", 32'(pulse), 32'h0);
    count = 16'h0030; tick();
    check_eq("basic_pulse",  32'(pulse),  32'h2);
    check_eq("basic_sticky", 32'(sticky), 32'h2);
    check_eq("basic_armed0", 32'(armed),  32'h0);
    check_eq("basic_any",    32'(any),    32'h1);
    check_eq("basic_ar_pulse", 32'(ar_pulse), 32'h2);

    // hold: no re-fire while count stays on target
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      pulses += int'(pulse[1]) + int'(ar_pulse[1]);
    end
    check_eq("hold_pulses", 32'(pulses), 32'h0);
    check_eq("hold_sticky", 32'(sticky), 32'h2);
    count = 16'h0031; tick();
    check_eq("rearm_ar_armed", 32'(ar_armed), 32'h2);
    check_eq("rearm_armed",    32'(armed),    32'h0);
    count = 16'h0030; tick();
    check_eq("rearm_ar_pulse", 32'(ar_pulse), 32'h2);
    check_eq("rearm_pulse",    32'(pulse),    32'h0);

    // collision: write wins over hit on ch2
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_value = 16'h0040; tick();
    idle_cfg(); cfg_arm = 1'b1; cfg_ch = 2'd2; tick();
    idle_cfg();
    check_eq("coll_armed", 32'(armed), 32'h4);
    count = 16'h0040; cfg_we = 1'b1; cfg_ch = 2'd2; cfg_value = 16'h0050; tick();
    idle_cfg();
    check_eq("coll_pulse",  32'(pulse),  32'h0);
    check_eq("coll_armed2", 32'(armed),  32'h0);
    check_eq("coll_sticky", 32'(sticky), 32'h2);
    check_eq("coll_ar_armed", 32'(ar_armed), 32'h2);
    // clear vs hit on ch1: hit wins
    cfg_arm = 1'b1; cfg_ch = 2'd1; tick();
    idle_cfg();
    count = 16'h0030; clr_sticky = 4'h2; tick();
    check_eq("clrhit_pulse",  32'(pulse),  32'h2);
    check_eq("clrhit_sticky", 32'(sticky), 32'h2);
    count = 16'h0031; clr_sticky = 4'h2; tick();
    idle_cfg();
    check_eq("clr_sticky", 32'(sticky), 32'h0);
    check_eq("clr_any",    32'(any),    32'h0);
    check_eq("clr_ar_sticky", 32'(ar_sticky), 32'h0);

    // multi: write+arm same cycle on all channels; ch3 is out of range for dut_ar
    for (int k = 0; k < 4; k++) begin
      cfg_we = 1'b1; cfg_arm = 1'b1; cfg_ch = 2'(k); cfg_value = 16'h0100; tick();
    end
    idle_cfg();
    check_eq("multi_armed",    32'(armed),    32'hF);
    check_eq("multi_ar_armed", 32'(ar_armed), 32'h7);
    // out-of-range write to dut_ar must not disturb its channels
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_value = 16'h0100; cfg_arm = 1'b1; tick();
    idle_cfg();
    check_eq("oor_ar_armed", 32'(ar_armed), 32'h7);
    count = 16'h0100; tick();
    check_eq("multi_pulse",    32'(pulse),    32'hF);
    check_eq("multi_sticky",   32'(sticky),   32'hF);
    check_eq("multi_any",      32'(any),      32'h1);
    check_eq("multi_ar_pulse", 32'(ar_pulse), 32'h7);
    count = 16'h0101; clr_sticky = 4'hF; tick();
    idle_cfg();
    check_eq("multi_clr_sticky", 32'(sticky), 32'h0);
    check_eq("multi_clr_any",    32'(any),    32'h0);
    check_eq("multi_clr_pulse",  32'(pulse),  32'h0);

    // wrap-around: target 0x0000 hit after count wraps from 0xFFFF
    cfg_we = 1'b1; cfg_arm = 1'b1; cfg_ch = 2'd0; cfg_value = 16'h0000; count = 16'hFFFF; tick();
    idle_cfg();
    tick();
    check_eq("wrap_ffff_pulse", 32'(pulse), 32'h0);
    count = 16'h0000; tick();
    check_eq("wrap_pulse", 32'(pulse), 32'h1);

    // mid-operation reset clears state and targets
    count = 16'h0005; cfg_arm = 1'b1; cfg_ch = 2'd1; tick();
    idle_cfg();
    check_eq("pre_rst_armed", 32'(armed), 32'h2);
    rst_n = 1'b0; tick();
    check_eq("midrst_armed",  32'(armed),  32'h0);
    check_eq("midrst_sticky", 32'(sticky), 32'h0);
    check_eq("midrst_any",    32'(any),    32'h0);
    rst_n = 1'b1; count = 16'h0000; cfg_arm = 1'b1; cfg_ch = 2'd2; tick();
    idle_cfg();
    tick();
    check_eq("rst_target_pulse", 32'(pulse), 32'h4);

`ifdef CMP_GE_MODE_EN
    // greater-or-equal mode on ch0
    cfg_we = 1'b1; cfg_arm = 1'b1; cfg_ge = 1'b1; cfg_ch = 2'd0; cfg_value = 16'h0050; count = 16'h0040; tick();
    idle_cfg();
    tick();
    check_eq("ge_below_pulse", 32'(pulse), 32'h0);
    count = 16'h0060; tick();
    check_eq("ge_pulse", 32'(pulse), 32'h1);
    cfg_we = 1'b1; cfg_arm = 1'b1; cfg_ge = 1'b0; cfg_ch = 2'd0; cfg_value = 16'h0050; count = 16'h0040; tick();
    idle_cfg();
    count = 16'h0060; tick();
    check_eq("eq_jump_pulse", 32'(pulse), 32'h0);
    check_eq("eq_jump_armed", 32'(armed[0]), 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
